lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store unit sitting directly upstream of `RAM` in the memory stage of the RISC-V core. Accepts one load or store request at a time from the execute stage. Converts it into word-aligned `RAM` accesses with per-byte lane selects, splitting misaligned accesses into two word cycles. Returns sign- or zero-extended load data, or a store acknowledge, through a valid/ready response handshake.

## Interface
- `ALLOW_MISALIGNED`, default 1: 1 means word-crossing accesses are split into two `RAM` cycles; 0 means they are rejected with `respErr`.

Ports:
- `clk` in 1: single clock; all state changes on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `reqValid` in 1: request present.
- `reqReady` out 1: unit can accept a request; 1 only in IDLE.
- `reqWe` in 1: 1 means store, 0 means load.
- `reqSize` in 2: 0 = byte, 1 = half, 2 = word, 3 = illegal.
- `reqUnsigned` in 1: loads only; 1 = zero-extend (LBU/LHU), 0 = sign-extend.
- `reqAddr` in 32: byte address.
- `reqWdata` in 32: store data, right-justified.
- `respValid` out 1: response available; held until `respReady`.
- `respReady` in 1: consumer accepts the response.
- `respData` out 32: extended load data; 0 for stores and errors.
- `respErr` out 1: illegal size, or misaligned with `ALLOW_MISALIGNED`=0.
- `memAddr` out 32: word address to `RAM`; low 2 bits always 0.
- `memSel` out 4: byte-lane enables; bit i = byte i of the word.
- `memWe` out 1: write strobe to `RAM`.
- `memWdata` out 32: lane-positioned write data to `RAM`.
- `memRdata` in 32: `RAM` read data, combinational from `memAddr`.

## Operation
- FSM states: IDLE, ACC0, ACC1, RESP.
- IDLE:
  - On `reqValid`&`reqReady`, register `reqWe`, `reqSize`, `reqUnsigned`, `reqAddr`, `reqWdata`.
  - Illegal request (size 3, or split needed with `ALLOW_MISALIGNED`=0): go to RESP with `respErr`=1 and `respData`=0. No `RAM` cycle is issued.
  - Otherwise go to ACC0.
- Width: n = 1, 2 or 4 bytes. o = addr[1:0]. A split is needed when o+n > 4.
- ACC0:
  - `memAddr`={addr[31:2],00}.
  - `memSel` = lanes o through min(o+n-1,3).
  - `memWdata` = low 32 bits of (wdata << 8·o), where wdata is the 64-bit zero-extended store data.
  - `memWe`=`reqWe`.
  - Loads capture `memRdata` into lo.
  - If a split is needed, go to ACC1; else go to RESP.
- ACC1:
  - `memAddr`=`memAddr`+4, wrapping modulo 2^32 (0xFFFFFFFC → 0).
  - `memSel` = lanes 0 through o+n-5.
  - `memWdata` = bits [63:32] of the shifted data.
  - Loads capture hi. Go to RESP.
- Load result:
  - Compute ({hi,lo} >> 8·o), truncate to n bytes.
  - Sign-extend, or zero-extend if `reqUnsigned`.
  - hi is 0 when no split occurred.
- RESP: `respValid`=1 and `respData`/`respErr` held stable until `respReady`, then return to IDLE.
- Outside ACC0/ACC1: `memWe`=0 and `memSel`=0. `memAddr`/`memWdata` hold their last value.
- `reqReady`=0 in every state except IDLE. No new request is accepted while a response is pending.

## Timing
- Reset, when `rst_n`=0 at a rising edge:
  - State goes to IDLE.
  - `reqReady`=0 while `rst_n` is low; 1 on the first cycle after release.
  - `respValid`=0, `respErr`=0, `respData`=0.
  - `memWe`=0, `memSel`=0, `memAddr`=0, `memWdata`=0.
- Reset mid-operation: the access is abandoned with no response. A split store whose ACC0 already completed leaves its first half written; there is no rollback.
- Latency, with acceptance at edge T:
  - ACC0 occupies cycle T+1.
  - `respValid` rises at T+2 for aligned or non-crossing accesses, and at T+3 for split accesses.
  - Error responses rise at T+1.
- Throughput: back-to-back aligned accesses take 3 cycles each when `respReady` is held at 1. `reqReady` returns to 1 in the cycle after the response is accepted.
- `respReady` asserted before `respValid` has no effect.

## Test plan
- Aligned word store then load: store 0x12345678 at 0x10 → `memSel`=1111, `memWe`=1 for one cycle, `respValid` at T+2. Load word from 0x10 → `respData`=0x12345678, `respErr`=0.
- Byte lanes: `RAM` word at 0x20 = 0x80FF7F01. LB at 0x23 → 0xFFFFFF80. LBU at 0x23 → 0x00000080. LH at 0x22 → 0xFFFF80FF. `memSel` = 1000 for each byte load at offset 3.
- Split word, `ALLOW_MISALIGNED`=1: SW 0xAABBCCDD at 0x41 → ACC0 addr 0x40, sel 1110, wdata 0xBBCCDD00. ACC1 addr 0x44, sel 0001, wdata 0x000000AA. LW at 0x41 returns 0xAABBCCDD at T+3.
- Error paths:
  - `reqSize`=3 → `respErr`=1 and `respData`=0 at T+1, with `memWe` never asserted.
  - With `ALLOW_MISALIGNED`=0, LH at 0x03 → `respErr`=1.
- Backpressure: hold `respReady`=0 for 5 cycles → `respValid` and `respData` stay stable, `reqReady`=0 throughout, and a `reqValid` pulse during the stall is ignored.
- Reset and wrap:
  - Drop `rst_n` during ACC1 of a split store → next cycle all outputs at reset values, state IDLE.
  - Split LW at 0xFFFFFFFE → ACC1 `memAddr`=0x00000000.

Source files
------------

// File: rtl/lsu_ctrl_if.sv
// Request/response handshake and word-RAM bus of the load/store unit.
// slave = the LSU itself; master = execute stage, response consumer and RAM.
interface lsu_ctrl_if;
  logic        reqValid;
  logic        reqReady;
  logic        reqWe;
  logic [1:0]  reqSize;
  logic        reqUnsigned;
  logic [31:0] reqAddr;
  logic [31:0] reqWdata;
  logic        respValid;
  logic        respReady;
  logic [31:0] respData;
  logic        respErr;
  logic [31:0] memAddr;
  logic [3:0]  memSel;
  logic        memWe;
  logic [31:0] memWdata;
  logic [31:0] memRdata;

  modport slave (
    input  reqValid, reqWe, reqSize, reqUnsigned, reqAddr, reqWdata,
    input  respReady, memRdata,
    output reqReady, respValid, respData, respErr,
    output memAddr, memSel, memWe, memWdata
  );

  modport master (
    output reqValid, reqWe, reqSize, reqUnsigned, reqAddr, reqWdata,
    output respReady, memRdata,
    input  reqReady, respValid, respData, respErr,
    input  memAddr, memSel, memWe, memWdata
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store unit: turns one byte/half/word request into one or two word-aligned
// RAM cycles with lane selects and returns extended load data or a store ack.
module lsu_ctrl #(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic      clk,
  input  logic      rst_n,
  lsu_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  state_t      r_state;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic        r_resp_err;
  logic [31:0] r_resp_data;
  logic [31:0] r_mem_addr;
  logic [3:0]  r_mem_sel;
  logic        r_mem_we;
  logic [31:0] r_mem_wdata;
  logic        r_we;
  logic        r_unsigned;
  logic        r_split;
  logic [1:0]  r_size;
  logic [1:0]  r_off;
  logic [31:0] r_wdata_hi;
  logic [3:0]  r_sel_hi;
  logic [31:0] r_lo;

  logic [1:0]  w_off;
  logic [3:0]  w_mask;
  logic [7:0]  w_sel;
  logic [63:0] w_wshift;
  logic        w_split;
  logic        w_illegal;
  logic        w_accept;

  // Lanes and data are laid out over a two-word window; anything landing in
  // the upper word means the access crosses a word boundary.
  always_comb begin
    w_off = bus.reqAddr[1:0];
    case (bus.reqSize)
      2'd0:    w_mask = 4'b0001;
      2'd1:    w_mask = 4'b0011;
      2'd2:    w_mask = 4'b1111;
      default: w_mask = 4'b0000;
    endcase
    w_sel     = {4'b0000, w_mask} << w_off;
    w_wshift  = {32'd0, bus.reqWdata} << {w_off, 3'b000};
    w_split   = |w_sel[7:4];
    w_illegal = (bus.reqSize == 2'd3) || (w_split && !ALLOW_MISALIGNED);
    w_accept  = bus.reqValid && r_req_ready;
  end

  function automatic logic [31:0] extend(input logic [63:0] raw, input logic [1:0] off,
                                         input logic [1:0] size, input logic uns);
    logic [31:0] s;
    s = 32'(raw >> {off, 3'b000});
    case (size)
      2'd0:    extend = {{24{s[7] & ~uns}}, s[7:0]};
      2'd1:    extend = {{16{s[15] & ~uns}}, s[15:0]};
      default: extend = s;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_data  <= 32'd0;
      r_mem_addr   <= 32'd0;
      r_mem_sel    <= 4'd0;
      r_mem_we     <= 1'b0;
      r_mem_wdata  <= 32'd0;
      r_we         <= 1'b0;
      r_unsigned   <= 1'b0;
      r_split      <= 1'b0;
      r_size       <= 2'd0;
      r_off        <= 2'd0;
      r_wdata_hi   <= 32'd0;
      r_sel_hi     <= 4'd0;
      r_lo         <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_req_ready <= 1'b1;
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_we        <= bus.reqWe;
            r_size      <= bus.reqSize;
            r_unsigned  <= bus.reqUnsigned;
            r_off       <= w_off;
            r_split     <= w_split;
            if (w_illegal) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_data  <= 32'd0;
            end else begin
              r_state     <= ACC0;
              r_resp_err  <= 1'b0;
              r_mem_addr  <= {bus.reqAddr[31:2], 2'b00};
              r_mem_sel   <= w_sel[3:0];
              r_mem_we    <= bus.reqWe;
              r_mem_wdata <= w_wshift[31:0];
              r_wdata_hi  <= w_wshift[63:32];
              r_sel_hi    <= w_sel[7:4];
            end
          end
        end
        ACC0: begin
          if (r_split) begin
            r_state     <= ACC1;
            r_mem_addr  <= r_mem_addr + 32'd4;
            r_mem_sel   <= r_sel_hi;
            r_mem_wdata <= r_wdata_hi;
            r_lo        <= bus.memRdata;
          end else begin
            r_state      <= RESP;
            r_mem_sel    <= 4'd0;
            r_mem_we     <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_data  <= r_we ? 32'd0 : extend({32'd0, bus.memRdata}, r_off, r_size, r_unsigned);
          end
        end
        ACC1: begin
          r_state      <= RESP;
          r_mem_sel    <= 4'd0;
          r_mem_we     <= 1'b0;
          r_resp_valid <= 1'b1;
          r_resp_data  <= r_we ? 32'd0 : extend({bus.memRdata, r_lo}, r_off, r_size, r_unsigned);
        end
        RESP: begin
          if (bus.respReady) begin
            r_state      <= IDLE;
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.reqReady  = r_req_ready;
  assign bus.respValid = r_resp_valid;
  assign bus.respErr   = r_resp_err;
  assign bus.respData  = r_resp_data;
  assign bus.memAddr   = r_mem_addr;
  assign bus.memSel    = r_mem_sel;
  assign bus.memWe     = r_mem_we;
  assign bus.memWdata  = r_mem_wdata;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: expected responses come from a byte-addressed
// reference memory; a monitor process pops and compares on each response handshake.
module tb_lsu_ctrl;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   rdy_rand = 1'b0;
  bit   rdy_force = 1'b1;

  bit [31:0] ram [256];
  bit [7:0]  ref_mem [1024];
  exp_t      q_a [$];
  exp_t      q_b [$];
  int          acc [2];
  bit          seen [2];
  int          first_cyc [2];
  logic [31:0] held [2];

  lsu_ctrl_if bus ();
  lsu_ctrl_if bus0 ();

  lsu_ctrl #(.ALLOW_MISALIGNED(1'b1)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  lsu_ctrl #(.ALLOW_MISALIGNED(1'b0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Word RAM shared by both units; only the misaligned-capable unit writes it.
  assign bus.memRdata  = ram[bus.memAddr[9:2]];
  assign bus0.memRdata = ram[bus0.memAddr[9:2]];
  always @(posedge clk) begin
    if (bus.memWe)
      for (int i = 0; i < 4; i++)
        if (bus.memSel[i]) ram[bus.memAddr[9:2]][8*i +: 8] <= bus.memWdata[8*i +: 8];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got timeout/extra event expected none", name);
  endtask

  // Reference: bytes live at (addr+i) mod 1024, little-endian, no notion of words.
  function automatic exp_t model(input bit allow, input bit we, input logic [1:0] size,
                                 input bit uns, input logic [31:0] addr, input logic [31:0] wdata);
    exp_t x;
    int n, o;
    logic [31:0] a;
    logic [63:0] v;
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    o = int'(addr[1:0]);
    x.data = 32'd0;
    x.err  = 1'b0;
    x.lat  = (o + n > 4) ? 3 : 2;
    if (size == 2'd3 || (!allow && o + n > 4)) begin
      x.err = 1'b1;
      x.lat = 1;
      return x;
    end
    v = 64'd0;
    for (int i = 0; i < n; i++) begin
      a = addr + 32'(i);
      if (we) ref_mem[a[9:0]] = wdata[8*i +: 8];
      else v = v | (64'(ref_mem[a[9:0]]) << (8 * i));
    end
    if (!we) begin
      if (!uns && v[8*n-1]) v = v | (~64'd0 << (8 * n));
      x.data = v[31:0];
    end
    return x;
  endfunction

  task automatic mon_step(input int s);
    logic v, r, e;
    logic [31:0] d;
    exp_t x;
    v = (s != 0) ? bus0.respValid : bus.respValid;
    r = (s != 0) ? bus0.respReady : bus.respReady;
    e = (s != 0) ? bus0.respErr : bus.respErr;
    d = (s != 0) ? bus0.respData : bus.respData;
    if (v !== 1'b1) begin
      seen[s] = 1'b0;
      return;
    end
    if (!seen[s]) begin
      seen[s] = 1'b1;
      first_cyc[s] = cyc;
      held[s] = d;
    end else begin
      check("resp_data_stable", d, held[s]);
    end
    if (r) begin
      seen[s] = 1'b0;
      if (((s != 0) ? q_b.size() : q_a.size()) == 0) begin
        fail("unexpected_resp");
      end else begin
        if (s != 0) x = q_b.pop_front();
        else x = q_a.pop_front();
        check("resp_data", d, x.data);
        check1("resp_err", e, x.err);
        check("latency", 32'(first_cyc[s] - acc[s] + 1), 32'(x.lat));
        $display("resp dut%0d data=0x%08h err=%b lat=%0d", s, d, e, first_cyc[s] - acc[s] + 1);
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    mon_step(0);
    mon_step(1);
  end

  initial begin
    bus.respReady  = 1'b1;
    bus0.respReady = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.respReady  = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
      bus0.respReady = rdy_force;
    end
  end

  task automatic drive(input int s, input bit vld, input bit we, input logic [1:0] size,
                       input bit uns, input logic [31:0] addr, input logic [31:0] wdata);
    if (s == 0) begin
      bus.reqValid = vld; bus.reqWe = we; bus.reqSize = size;
      bus.reqUnsigned = uns; bus.reqAddr = addr; bus.reqWdata = wdata;
    end else begin
      bus0.reqValid = vld; bus0.reqWe = we; bus0.reqSize = size;
      bus0.reqUnsigned = uns; bus0.reqAddr = addr; bus0.reqWdata = wdata;
    end
  endtask

  // Returns #1 after the accepting edge, i.e. inside the ACC0 cycle.
  task automatic do_req(input int s, input bit we, input logic [1:0] size, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
    int w = 0;
    exp_t x;
    while (!((s != 0) ? bus0.reqReady : bus.reqReady) && w < 100) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (w >= 100) begin
      fail("req_ready_timeout");
      return;
    end
    x = model(s == 0, we, size, uns, addr, wdata);
    if (s != 0) q_b.push_back(x);
    else q_a.push_back(x);
    $display("req  dut%0d we=%b size=%0d uns=%b addr=0x%08h wdata=0x%08h", s, we, size, uns, addr, wdata);
    drive(s, 1'b1, we, size, uns, addr, wdata);
    @(posedge clk);
    #1;
    acc[s] = cyc;
    drive(s, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic wait_drain(input int s);
    int w = 0;
    while ((((s != 0) ? q_b.size() : q_a.size()) != 0 ||
            !((s != 0) ? bus0.reqReady : bus.reqReady)) && w < 100) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (w >= 100) fail("drain_timeout");
  endtask

  task automatic check_mem(input string name, input logic [31:0] addr, input logic [3:0] sel,
                           input logic we, input logic [31:0] wdata);
    check({name, "_addr"}, bus.memAddr, addr);
    check({name, "_sel"}, 32'(bus.memSel), 32'(sel));
    check1({name, "_we"}, bus.memWe, we);
    check({name, "_wdata"}, bus.memWdata, wdata);
  endtask

  task automatic check_reset_outputs(input string name);
    check1({name, "_req_ready"}, bus.reqReady, 1'b0);
    check1({name, "_resp_valid"}, bus.respValid, 1'b0);
    check1({name, "_resp_err"}, bus.respErr, 1'b0);
    check({name, "_resp_data"}, bus.respData, 32'd0);
    check1({name, "_mem_we"}, bus.memWe, 1'b0);
    check({name, "_mem_sel"}, 32'(bus.memSel), 32'd0);
    check({name, "_mem_addr"}, bus.memAddr, 32'd0);
    check({name, "_mem_wdata"}, bus.memWdata, 32'd0);
  endtask

  initial begin
    int w;
    int t0;
    drive(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check1("req_ready_after_reset", bus.reqReady, 1'b1);

    // Aligned word store and load
    do_req(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h12345678);
    check_mem("sw_acc0", 32'h10, 4'b1111, 1'b1, 32'h12345678);
    @(posedge clk);
    #1;
    check1("sw_we_one_cycle", bus.memWe, 1'b0);
    do_req(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0);

    // Byte lanes
    do_req(0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h80FF7F01);
    do_req(0, 1'b0, 2'd0, 1'b0, 32'h23, 32'd0);
    check("lb_sel", 32'(bus.memSel), 32'h8);
    do_req(0, 1'b0, 2'd0, 1'b1, 32'h23, 32'd0);
    check("lbu_sel", 32'(bus.memSel), 32'h8);
    do_req(0, 1'b0, 2'd1, 1'b0, 32'h22, 32'd0);
    check("lh_sel", 32'(bus.memSel), 32'hC);

    // Split word store and load
    do_req(0, 1'b1, 2'd2, 1'b0, 32'h41, 32'hAABBCCDD);
    check_mem("split_acc0", 32'h40, 4'b1110, 1'b1, 32'hBBCCDD00);
    @(posedge clk);
    #1;
    check_mem("split_acc1", 32'h44, 4'b0001, 1'b1, 32'h000000AA);
    do_req(0, 1'b0, 2'd2, 1'b0, 32'h41, 32'd0);

    // Illegal size: no RAM cycle, error response one cycle after acceptance
    do_req(0, 1'b1, 2'd3, 1'b0, 32'h08, 32'hFFFFFFFF);
    check1("size3_no_we", bus.memWe, 1'b0);
    check("size3_no_sel", 32'(bus.memSel), 32'd0);
    do_req(0, 1'b0, 2'd3, 1'b1, 32'h0C, 32'd0);

    // Unit without misaligned support
    do_req(1, 1'b0, 2'd1, 1'b0, 32'h03, 32'd0);
    do_req(1, 1'b0, 2'd1, 1'b1, 32'h22, 32'd0);
    do_req(1, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
    do_req(1, 1'b0, 2'd2, 1'b0, 32'h42, 32'd0);
    wait_drain(1);

    // Throughput with respReady held high
    wait_drain(0);
    do_req(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
    t0 = acc[0];
    for (int i = 1; i < 4; i++) begin
      do_req(0, 1'b0, 2'd2, 1'b0, 32'(i * 4), 32'd0);
      check("throughput", 32'(acc[0] - t0), 32'd3);
      t0 = acc[0];
    end

    // Backpressure with an ignored request pulse
    wait_drain(0);
    rdy_force = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    do_req(0, 1'b0, 2'd2, 1'b0, 32'h20, 32'd0);
    w = 0;
    while (!bus.respValid && w < 10) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (w >= 10) fail("stall_resp_timeout");
    for (int k = 0; k < 5; k++) begin
      check1("stall_valid", bus.respValid, 1'b1);
      check1("stall_req_ready", bus.reqReady, 1'b0);
      if (k == 2) drive(0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h23, 32'd0);
      @(posedge clk);
      #1;
      drive(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    end
    rdy_force = 1'b1;
    wait_drain(0);
    repeat (3) @(posedge clk);
    #1;
    check1("no_ghost_resp", bus.respValid, 1'b0);

    // Random traffic with random response backpressure
    rdy_rand = 1'b1;
    for (int i = 0; i < 200; i++) begin
      logic [2:0] r;
      logic [31:0] addr;
      r = 3'($urandom_range(0, 7));
      addr = ($urandom_range(0, 1) != 0) ? $urandom() : $urandom_range(0, 255);
      do_req(0, 1'($urandom_range(0, 1)), (r == 3'd7) ? 2'd3 : 2'(r % 3),
             1'($urandom_range(0, 1)), addr, $urandom());
    end
    rdy_rand = 1'b0;
    wait_drain(0);

    // Split load across the top of the address space
    do_req(0, 1'b0, 2'd2, 1'b0, 32'hFFFFFFFE, 32'd0);
    check("wrap_acc0_addr", bus.memAddr, 32'hFFFFFFFC);
    check("wrap_acc0_sel", 32'(bus.memSel), 32'hC);
    @(posedge clk);
    #1;
    check("wrap_acc1_addr", bus.memAddr, 32'h00000000);
    check("wrap_acc1_sel", 32'(bus.memSel), 32'h3);
    wait_drain(0);

    // Reset during ACC1 of a split store abandons the access
    do_req(0, 1'b1, 2'd2, 1'b0, 32'h301, 32'h5A5A1234);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("mid_reset");
    q_a.delete();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check1("req_ready_after_mid_reset", bus.reqReady, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check1("no_resp_after_abandon", bus.respValid, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
